// File: rtl/toy_pkg.sv
// Shared types and the toy next-output function for the result checker.
package toy_pkg;

  typedef enum logic [1:0] {
    WARM0 = 2'd0,
    WARM1 = 2'd1,
    CHECK = 2'd2,
    FAIL  = 2'd3
  } toy_chk_state_t;

  // Toy output one cycle ahead: OR of the last two inputs, or the older
  // input gated by bit 0 of the newer one.
  function automatic logic [1:0] toy_next_out(input logic op, input logic [1:0] in_v,
                                              input logic [1:0] tmp);
    return op ? (tmp | in_v) : (tmp & {2{in_v[0]}});
  endfunction

endpackage

// File: rtl/toy_ref_model.sv
// Cycle-accurate reference of the toy datapath: previous input and prediction.
module toy_ref_model
  import toy_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_obs_in,
  input  logic       i_obs_op,
  output logic [1:0] o_pred
);

  logic [1:0] r_prev_in;
  logic [1:0] r_pred;

  // History runs every cycle regardless of checker state or clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_in <= 2'b00;
      r_pred    <= 2'b00;
    end else begin
      r_prev_in <= i_obs_in;
      r_pred    <= toy_next_out(i_obs_op, i_obs_in, r_prev_in);
    end
  end

  assign o_pred = r_pred;

endmodule

// File: rtl/toy_result_checker.sv
// Scoreboard for the toy datapath: warm-up FSM, miscompare flagging,
// saturating error count and all-ones run detection.
module toy_result_checker
  import toy_pkg::*;
#(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       obs_in,
  input  logic             obs_op,
  input  logic [1:0]       obs_out,
  input  logic             clr,
  output logic             mismatch,
  output logic             fail_sticky,
  output logic [CNT_W-1:0] err_cnt,
  output logic             run_hit,
  output logic [1:0]       state
);

  localparam logic [CNT_W-1:0] RUN_LEN_W = RUN_LEN[CNT_W-1:0];

  toy_chk_state_t   r_state;
  logic             r_mismatch;
  logic             r_sticky;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_run_cnt;
  logic             r_run_hit;

  logic [1:0]       w_pred;
  logic             w_cmp_en;
  logic             w_miscmp;
  logic [CNT_W-1:0] w_run_nxt;

  toy_ref_model u_ref (
    .clk      (clk),
    .reset    (reset),
    .i_obs_in (obs_in),
    .i_obs_op (obs_op),
    .o_pred   (w_pred)
  );

  assign w_cmp_en = (r_state == CHECK) || (r_state == FAIL);
  assign w_miscmp = w_cmp_en && (obs_out != w_pred);

  // Next run length: saturating count of all-ones results while comparing.
  always_comb begin
    w_run_nxt = '0;
    if (w_cmp_en && (obs_out == 2'b11))
      w_run_nxt = (r_run_cnt == '1) ? r_run_cnt : r_run_cnt + 1'b1;
  end

  // FSM, counters and registered outputs; clear wins over a same-cycle miscompare.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= WARM0;
      r_mismatch <= 1'b0;
      r_sticky   <= 1'b0;
      r_err_cnt  <= '0;
      r_run_cnt  <= '0;
      r_run_hit  <= 1'b0;
    end else begin
      r_mismatch <= w_miscmp;
      case (r_state)
        WARM0:   r_state <= WARM1;
        WARM1:   r_state <= CHECK;
        CHECK:   if (w_miscmp && !clr) r_state <= FAIL;
        FAIL:    if (clr) r_state <= CHECK;
        default: r_state <= WARM0;
      endcase
      if (clr) begin
        r_sticky  <= 1'b0;
        r_err_cnt <= '0;
        r_run_cnt <= '0;
        r_run_hit <= 1'b0;
      end else begin
        if (w_miscmp) begin
          r_sticky <= 1'b1;
          if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
        end
        r_run_cnt <= w_run_nxt;
        r_run_hit <= (w_run_nxt >= RUN_LEN_W);
      end
    end
  end

  assign mismatch    = r_mismatch;
  assign fail_sticky = r_sticky;
  assign err_cnt     = r_err_cnt;
  assign run_hit     = r_run_hit;
  assign state       = r_state;

endmodule

// File: doc/toy_result_checker.md
# toy_result_checker

Downstream scoreboard for the `toy` datapath, instantiated beside it in the `top` harness. It snoops the same registered `in`/`op` the toy consumes, plus the toy's `out`. It keeps a cycle-accurate reference model and flags every mismatch after a fixed warm-up. It also detects runs of all-ones results, generalising `fail_out`, and exposes sticky failure state for formal properties and simulation benches.

## Interface
- `RUN_LEN`, default 4: consecutive `out==2'b11` cycles that raise `run_hit`; legal range 1..2^CNT_W-1.
- `CNT_W`, default 8: width of the saturating error counter and the run counter.
- `clk`  input  1  rising-edge clock shared with `toy`.
- `reset`  input  1  asynchronous, active-high; one clock; all state cleared on assertion.
- `obs_in`  input  2  value driven on the toy's `in` this cycle.
- `obs_op`  input  1  value driven on the toy's `op` this cycle.
- `obs_out`  input  2  the toy's `out` this cycle.
- `clr`  input  1  synchronous clear of `err_cnt`, `fail_sticky`, run counter and `run_hit`; model history is untouched.
- `mismatch`  output  1  registered one-cycle pulse per miscompare.
- `fail_sticky`  output  1  set on first mismatch; held until `clr` or `reset`.
- `err_cnt`  output  CNT_W  saturating mismatch count.
- `run_hit`  output  1  high while the all-ones run length is at least `RUN_LEN`.
- `state`  output  2  FSM state encoding from the package.

## Operation
- **Reference model:**
  - `prev_in <= obs_in` every cycle.
  - `pred <= obs_op ? (prev_in | obs_in) : (prev_in & {2{obs_in[0]}})`.
  - `pred` in cycle c+1 must equal the toy's `out` in cycle c+1.
- **FSM states:** WARM0, WARM1, CHECK, FAIL.
  - `reset` → WARM0.
  - WARM0 → WARM1 unconditionally; `prev_in` is now valid.
  - WARM1 → CHECK unconditionally; `pred` is now valid.
  - CHECK → FAIL on a miscompare.
  - FAIL → CHECK on `clr`.
  - No other transitions.
- **Compare:** active only in CHECK and FAIL. Miscompare = `obs_out != pred`. No compare and no run counting in WARM0/WARM1.
- **On a miscompare:**
  - `mismatch` = 1 next cycle.
  - `err_cnt` += 1, saturating at all-ones.
  - `fail_sticky` = 1.
  - Comparison continues in FAIL.
- **Run counter:**
  - Increments, saturating, when `obs_out == 2'b11` in CHECK/FAIL; otherwise resets to 0.
  - `run_hit` = (run counter ≥ `RUN_LEN`), registered.
- **`clr` priority:** `clr` beats a same-cycle miscompare. Counter, sticky and run counter go to 0; `mismatch` still pulses; the state goes to CHECK.
- **Reset mid-operation:** everything returns to WARM0 and zero immediately. Warm-up restarts; no stale compare is possible.

## Timing
- **Reset values:** `mismatch` = 0, `fail_sticky` = 0, `err_cnt` = 0, `run_hit` = 0, `state` = WARM0, `prev_in` = 0, `pred` = 0.
- **First compare:** the third rising edge after `reset` deasserts, i.e. the cycle in which `state` first reads CHECK.
- **Miscompare latency:** `obs_out` wrong in cycle c → `mismatch`/`fail_sticky`/`err_cnt` visible in cycle c+1.
- **Run latency:** all-ones in cycles c..c+RUN_LEN-1 → `run_hit` high in cycle c+RUN_LEN. It falls one cycle after the first non-all-ones `obs_out`.
- **Outputs:** all registered; no combinational input-to-output paths.

## Structure
- **Package `toy_pkg`:**
  - `toy_chk_state_t` (2-bit enum WARM0=0, WARM1=1, CHECK=2, FAIL=3).
  - Function `toy_next_out(op, in, tmp)`; the harness reuses it for properties.
- **Sub-module `toy_ref_model`:**
  - Holds `prev_in`/`pred`.
  - Clocked by `clk`/`reset` only.
- **Checker:** FSM, counters and outputs.

## Test plan
- **Reset then idle:** `obs_in` = 00, `obs_op` = 0, `obs_out` = 00 → `state` WARM0, WARM1, then CHECK; all other outputs stay 0.
- **Correct OR path:** `in` = 01 then 10 with `op` = 1, toy `out` = 11 next cycle → no `mismatch`. Holding `out` = 11 for 4 cycles raises `run_hit` with `RUN_LEN` = 4.
- **Injected error:** AND path, `in` = 01 then 10 with `op` = 0, expected `out` = 00; drive 01 → `mismatch` pulse one cycle later, `fail_sticky` = 1, `err_cnt` = 1, `state` = FAIL.
- **Saturation:** `CNT_W` = 2 with 5 consecutive miscompares → `err_cnt` stops at 3; `mismatch` pulses all 5 times.
- **Clear vs. miscompare:** `clr` in the same cycle as a miscompare → `err_cnt` = 0, `fail_sticky` = 0, `mismatch` = 1, `state` = CHECK.
- **Reset mid-FAIL:** assert `reset` with `err_cnt` = 2 → all outputs are 0 asynchronously, and a bad `obs_out` during WARM0/WARM1 produces no `mismatch`.
